// File: rtl/adc_capture.sv
// ADC sample capture: clock divider, pipeline flush, sample counter
// and a synchronous sample FIFO drained by the host.
module adc_capture #(
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DLY   = 3,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        hclk,
  input  logic        hreset,
  output logic        adc_clk,
  input  logic [7:0]  adc_data,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] sample_count,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam state_t S_FIRST =
    (PIPE_DLY == 0) ? S_CAPTURE : S_FLUSH;

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_nxt;
  logic          r_adc_clk;
  logic [7:0]    r_adc_q;
  logic          w_strobe;

  state_t        r_state;
  logic [15:0]   r_limit;
  logic [15:0]   r_smp_cnt;
  logic [15:0]   r_fl_cnt;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   w_cnt_inc;
  logic          w_hit;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_start_ok;
  logic          w_wr_req;
  logic          w_wr;
  logic          w_pop;

  assign w_strobe  = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_div_nxt = w_strobe ? '0 : r_div_cnt + DW'(1);

  // adc_clk is registered from the next divider value so it lines
  // up with div_cnt: low for the first half of the period.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_div_cnt <= '0;
      r_adc_clk <= 1'b0;
      r_adc_q   <= '0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_adc_clk <= (w_div_nxt >= DW'(CLK_DIV / 2));
      r_adc_q   <= adc_data;
    end
  end

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_wr_req   = (r_state == S_CAPTURE) && w_strobe;
  assign w_pop      = rd_en && !w_empty && !w_start_ok;
  assign w_wr       = w_wr_req && (!w_full || w_pop);
  assign w_cnt_inc  = r_smp_cnt + 16'd1;
  // Dropped samples still count toward the requested total.
  assign w_hit      = w_wr_req && (r_limit != '0)
                      && (w_cnt_inc == r_limit);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= S_IDLE;
      r_limit   <= '0;
      r_smp_cnt <= '0;
      r_fl_cnt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_limit   <= sample_count;
            r_smp_cnt <= '0;
            r_fl_cnt  <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_FIRST;
          end
        end
        S_FLUSH: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_strobe) begin
            r_fl_cnt <= r_fl_cnt + 16'd1;
            if (r_fl_cnt == 16'(PIPE_DLY - 1))
              r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_strobe)
            r_smp_cnt <= w_cnt_inc;
          if (stop || w_hit) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (w_wr)
      r_mem[r_wp] <= r_adc_q;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop)
        r_rd_data <= r_mem[r_rp];
      if (w_start_ok) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr)
          r_wp <= r_wp + AW'(1);
        if (w_pop)
          r_rp <= r_rp + AW'(1);
        if (w_wr_req && !w_wr)
          r_ovf <= 1'b1;
        unique case ({w_wr, w_pop})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign adc_clk    = r_adc_clk;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: cycle-indexed reference model feeding a
// scoreboard of popped samples, plus per-cycle status checks.
module tb_adc_capture;

  localparam int CD    = 4;
  localparam int PD    = 3;
  localparam int DEPTH = 8;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        adc_clk;
  logic [7:0]  adc_data = 8'd0;
  logic        start;
  logic        stop;
  logic [15:0] sample_count;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  adc_capture #(
    .CLK_DIV(CD),
    .PIPE_DLY(PD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .adc_clk(adc_clk),
    .adc_data(adc_data),
    .start(start),
    .stop(stop),
    .sample_count(sample_count),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .done(done),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 hclk = ~hclk;

  // ADC source: a ramp stepping on every adc_clk rise, or random bytes
  logic       ramp_mode = 1'b1;
  logic [7:0] ramp = 8'd0;

  always @(posedge adc_clk) ramp = ramp + 8'd1;

  always @(negedge hclk)
    adc_data = ramp_mode ? ramp : 8'($urandom);

  // Reference model: cycle index since reset, strobe every CD-th cycle
  int          mn = 0;
  bit          m_init = 0;
  bit          m_rst = 0;
  bit          m_run = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_rv = 0;
  int          m_seen = 0;
  logic [15:0] m_cap = '0;
  logic [15:0] m_limit = '0;
  logic [7:0]  m_prev = '0;
  logic [7:0]  q[$];
  logic [7:0]  exp_q[$];

  always @(posedge hclk) begin
    bit stb;
    bit pop;
    bit wr;
    bit fin;
    bit acc;
    if (hreset) begin
      mn = 0;
      m_init = 1;
      m_rst = 1;
      m_run = 0;
      m_done = 0;
      m_ovf = 0;
      m_rv = 0;
      q.delete();
      exp_q.delete();
    end else begin
      m_rst = 0;
      stb = ((mn % CD) == CD - 1);
      wr = 0;
      fin = 0;
      acc = 0;
      if (m_run) begin
        if (stb) begin
          if (m_seen >= PD) begin
            wr = 1;
            m_cap = m_cap + 16'd1;
          end
          m_seen++;
        end
        if (stop || (wr && m_limit != 0 && m_cap == m_limit))
          fin = 1;
      end else if (!m_done && start) begin
        acc = 1;
        q.delete();
        m_ovf = 0;
        m_seen = 0;
        m_cap = '0;
        m_limit = sample_count;
        m_run = 1;
      end
      pop = rd_en && (q.size() > 0) && !acc;
      if (pop)
        exp_q.push_back(q.pop_front());
      if (wr) begin
        if (q.size() < DEPTH)
          q.push_back(m_prev);
        else
          m_ovf = 1;
      end
      m_rv = pop;
      if (fin)
        m_run = 0;
      m_done = fin;
      mn++;
    end
    m_prev = adc_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: status every cycle, popped data against the scoreboard
  always @(negedge hclk) begin
    if (m_init) begin
      chk("adc_clk", 32'(adc_clk), 32'((mn % CD) >= CD / 2));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      if (m_rst)
        chk("rd_data_rst", 32'(rd_data), 32'd0);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0)
          chk("rd_data_unexpected", 32'd1, 32'd0);
        else
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end else if (m_rv && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic pulse_start(input logic [15:0] cnt);
    sample_count = cnt;
    start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
  endtask

  // rdm: 0 never read, 1 random reads, 2 read every cycle
  task automatic run(input logic [15:0] cnt, input int stop_at,
                     input int rdm, input int budget);
    bit got = 0;
    pulse_start(cnt);
    for (int k = 0; k < budget && !got; k++) begin
      rd_en = (rdm == 2) ? 1'b1 :
              (rdm == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop = (k == stop_at);
      if (k == 6)
        start = 1'b1;
      else
        start = 1'b0;
      @(negedge hclk);
      if (done === 1'b1)
        got = 1;
    end
    start = 1'b0;
    stop = 1'b0;
    rd_en = 1'b0;
    if (!got)
      chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    cyc(n);
    rd_en = 1'b0;
  endtask

  initial begin
    hreset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    rd_en = 1'b0;
    sample_count = '0;
    cyc(3);
    hreset = 1'b0;
    cyc(5 + $urandom_range(0, 3));

    // ramp capture of 10 samples, reading continuously
    run(16'd10, -1, 2, 300);
    cyc(2);
    stop = 1'b1;
    @(negedge hclk);
    stop = 1'b0;
    drain(12);

    // continuous capture with random data, stop after ~20 strobes
    ramp_mode = 1'b0;
    cyc($urandom_range(0, 3));
    run(16'd0, (PD + 20) * CD + 1, 1, 400);
    drain(DEPTH + 4);

    // overflow: 12 samples into an 8-deep FIFO with no reads
    run(16'd12, -1, 0, 300);
    cyc(3);
    run(16'd5, -1, 1, 300);
    drain(DEPTH + 2);

    // fill, then read every cycle while strobes keep arriving
    pulse_start(16'd0);
    cyc((PD + DEPTH) * CD - 2);
    rd_en = 1'b1;
    cyc(40);
    stop = 1'b1;
    @(negedge hclk);
    stop = 1'b0;
    cyc(DEPTH + 6);
    rd_en = 1'b0;

    // start and stop together in idle: start wins
    sample_count = 16'd3;
    start = 1'b1;
    stop = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    stop = 1'b0;
    rd_en = 1'b1;
    cyc(40);
    rd_en = 1'b0;

    // reset in the middle of a capture
    pulse_start(16'd0);
    cyc(30 + $urandom_range(0, 5));
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    cyc(6);

    // randomized runs
    for (int i = 0; i < 6; i++) begin
      automatic int c = $urandom_range(0, 14);
      automatic int s = (c == 0) ? $urandom_range(4, 80)
                      : (($urandom_range(0, 3) == 0)
                         ? $urandom_range(2, 40) : -1);
      cyc($urandom_range(1, 4));
      run(16'(c), s, 1, 400);
      drain(DEPTH + 2);
    end

    cyc(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
